mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_if.sv | 36 +++
 rtl/arb_select.sv | 20 ++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_DM = 2'd2,
    RESP     = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_DM = 1'b0,
    PORT_IF = 1'b1
  } port_sel_t;

  localparam int TIMEOUT_DEFAULT = 15;
  localparam int WAIT_CNT_MAX    = 15;

endpackage

// File: rtl/mem_arb_if.sv
// Fetch, data and memory-side signals of the arbiter; slave is the arbiter's view.
interface mem_arb_if #(
  parameter int WORD_SIZE = 16
);
  logic                 if_req;
  logic [WORD_SIZE-1:0] if_addr;
  logic [WORD_SIZE-1:0] if_rdata;
  logic                 if_ready;
  logic                 dm_read;
  logic                 dm_write;
  logic [WORD_SIZE-1:0] dm_addr;
  logic [WORD_SIZE-1:0] dm_wdata;
  logic [WORD_SIZE-1:0] dm_rdata;
  logic                 dm_ready;
  logic                 mem_read;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_ack;
  logic                 stall_if;
  logic                 stall_mem;
  logic                 timeout_err;

  modport slave (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_read, mem_write, mem_addr,
           mem_wdata, stall_if, stall_mem, timeout_err
  );

  modport master (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_read, mem_write, mem_addr,
           mem_wdata, stall_if, stall_mem, timeout_err
  );
endinterface

// File: rtl/arb_select.sv
// Two-requester grant decision: a lone requester wins; on contention the port not served last wins.
module arb_select
  import mem_arb_pkg::*;
(
  input  logic      req_if,
  input  logic      req_dm,
  input  port_sel_t last_grant,
  output port_sel_t grant
);

  always_comb begin
    grant = PORT_DM;
    if (req_if && req_dm) begin
      grant = (last_grant == PORT_DM) ? PORT_IF : PORT_DM;
    end else if (req_if) begin
      grant = PORT_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one shared memory port with ack timeout.
// Define MEM_ARB_FAIR_EN for round-robin on contention; default is fixed data priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input logic      clk,
  input logic      reset,
  mem_arb_if.slave bus
);

  localparam logic [4:0] TIMEOUT_LIM = 5'((TIMEOUT > WAIT_CNT_MAX) ? WAIT_CNT_MAX : TIMEOUT);

  arb_state_t           state_reg;
  logic [3:0]           wait_cnt_reg;
  logic                 timeout_err_reg;
  logic                 if_ready_reg;
  logic                 dm_ready_reg;
  logic                 mem_read_reg;
  logic                 mem_write_reg;
  logic [WORD_SIZE-1:0] if_rdata_reg;
  logic [WORD_SIZE-1:0] dm_rdata_reg;
  logic [WORD_SIZE-1:0] mem_addr_reg;
  logic [WORD_SIZE-1:0] mem_wdata_reg;
  logic                 dm_req;
  logic                 timed_out;
  port_sel_t            last_grant;
  port_sel_t            grant_sel;

  assign dm_req    = bus.dm_read | bus.dm_write;
  // Abort in the cycle whose miss would bring the count up to the limit.
  assign timed_out = ({1'b0, wait_cnt_reg} + 5'd1) == TIMEOUT_LIM;

`ifdef MEM_ARB_FAIR_EN
  port_sel_t last_grant_reg;
  assign last_grant = last_grant_reg;
`else
  // Pretending fetch was served last makes the selector always favour data.
  assign last_grant = PORT_IF;
`endif

  arb_select u_arb_select (
    .req_if     (bus.if_req),
    .req_dm     (dm_req),
    .last_grant (last_grant),
    .grant      (grant_sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
      if_ready_reg    <= 1'b0;
      dm_ready_reg    <= 1'b0;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
      if_rdata_reg    <= '0;
      dm_rdata_reg    <= '0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
`ifdef MEM_ARB_FAIR_EN
      last_grant_reg  <= PORT_DM;
`endif
    end else begin
      if_ready_reg <= 1'b0;
      dm_ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.if_req || dm_req) begin
            wait_cnt_reg <= '0;
`ifdef MEM_ARB_FAIR_EN
            last_grant_reg <= grant_sel;
`endif
            if (grant_sel == PORT_DM) begin
              // A simultaneous read+write is taken as a write.
              state_reg     <= GRANT_DM;
              mem_addr_reg  <= bus.dm_addr;
              mem_wdata_reg <= bus.dm_wdata;
              mem_write_reg <= bus.dm_write;
              mem_read_reg  <= ~bus.dm_write;
            end else begin
              state_reg     <= GRANT_IF;
              mem_addr_reg  <= bus.if_addr;
              mem_wdata_reg <= '0;
              mem_write_reg <= 1'b0;
              mem_read_reg  <= 1'b1;
            end
          end
        end
        GRANT_IF, GRANT_DM: begin
          if (bus.mem_ack || timed_out) begin
            state_reg     <= RESP;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            if (state_reg == GRANT_IF) begin
              if_rdata_reg <= bus.mem_ack ? bus.mem_rdata : '0;
              if_ready_reg <= 1'b1;
            end else begin
              dm_rdata_reg <= bus.mem_ack ? bus.mem_rdata : '0;
              dm_ready_reg <= 1'b1;
            end
            if (!bus.mem_ack) begin
              timeout_err_reg <= 1'b1;
            end
          end
          if (!bus.mem_ack) begin
            wait_cnt_reg <= (wait_cnt_reg == 4'hF) ? wait_cnt_reg : wait_cnt_reg + 4'd1;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.if_rdata    = if_rdata_reg;
  assign bus.if_ready    = if_ready_reg;
  assign bus.dm_rdata    = dm_rdata_reg;
  assign bus.dm_ready    = dm_ready_reg;
  assign bus.mem_read    = mem_read_reg;
  assign bus.mem_write   = mem_write_reg;
  assign bus.mem_addr    = mem_addr_reg;
  assign bus.mem_wdata   = mem_wdata_reg;
  assign bus.timeout_err = timeout_err_reg;
  assign bus.stall_if    = bus.if_req & ~if_ready_reg;
  assign bus.stall_mem   = dm_req & ~dm_ready_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random and directed rounds against a transaction-level model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;

  mem_arb_if #(.WORD_SIZE(16)) bus ();

  mem_arbiter #(.WORD_SIZE(16), .TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    bit          wr;
    logic [15:0] wdata;
    int          lat;
  } acc_t;

  typedef struct {
    bit          is_if;
    logic [15:0] rdata;
    bit          err;
  } resp_t;

  acc_t        acc_q[$];
  resp_t       exp_q[$];
  logic [15:0] model_mem [logic [15:0]];
  logic [15:0] phys_mem  [logic [15:0]];
  bit          model_err;
  bit          model_last_if;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] default_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // Model: one access in grant order; timeout when memory takes more than 15 grant cycles.
  task automatic push_access(input bit is_if, input logic [15:0] addr, input bit wr,
                             input logic [15:0] wdata, input int lat);
    acc_t        a;
    resp_t       r;
    logic [15:0] old;
    a.addr = addr; a.wr = wr; a.wdata = wdata; a.lat = lat;
    acc_q.push_back(a);
    old = model_mem.exists(addr) ? model_mem[addr] : default_word(addr);
    model_err = model_err || (lat > 15);
    r.is_if = is_if;
    r.rdata = (lat > 15) ? 16'h0000 : old;
    r.err   = model_err;
    if (wr && lat <= 15) model_mem[addr] = wdata;
    exp_q.push_back(r);
    model_last_if = is_if;
  endtask

  task automatic start_round(input bit r_if, input bit r_dmr, input bit r_dmw,
                             input logic [15:0] ia, input logic [15:0] da, input logic [15:0] dw,
                             input int lat_if, input int lat_dm);
    bit r_dm;
    bit if_first;
    r_dm     = r_dmr | r_dmw;
    if_first = r_if && !r_dm;
`ifdef MEM_ARB_FAIR_EN
    if (r_if && r_dm) if_first = !model_last_if;
`endif
    if (if_first) begin
      push_access(1'b1, ia, 1'b0, 16'h0, lat_if);
      if (r_dm) push_access(1'b0, da, r_dmw, dw, lat_dm);
    end else begin
      if (r_dm) push_access(1'b0, da, r_dmw, dw, lat_dm);
      if (r_if) push_access(1'b1, ia, 1'b0, 16'h0, lat_if);
    end
    bus.if_req   = r_if;
    bus.if_addr  = ia;
    bus.dm_read  = r_dmr;
    bus.dm_write = r_dmw;
    bus.dm_addr  = da;
    bus.dm_wdata = dw;
  endtask

  task automatic finish_round(input bit p_if, input bit p_dm);
    for (int c = 0; c < 100 && (p_if || p_dm); c++) begin
      @(negedge clk);
      if (p_if && bus.if_ready) begin
        bus.if_req = 1'b0;
        p_if = 1'b0;
      end
      if (p_dm && bus.dm_ready) begin
        bus.dm_read  = 1'b0;
        bus.dm_write = 1'b0;
        p_dm = 1'b0;
      end
    end
    n_checks++;
    if (p_if || p_dm) begin
      n_errors++;
      $display("FAIL round_timeout: pending if=%0d dm=%0d expected none", p_if, p_dm);
      bus.if_req = 1'b0; bus.dm_read = 1'b0; bus.dm_write = 1'b0;
    end
  endtask

  function automatic int rand_lat();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(14, 17));
    return int'($urandom_range(1, 5));
  endfunction

  // Memory responder: acks after the planned number of grant cycles and checks the request.
  bit   resp_active;
  bit   resp_bogus;
  int   resp_cnt;
  acc_t cur_acc;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0;
    resp_active   = 1'b0;
    resp_bogus    = 1'b0;
    resp_cnt      = 0;
    forever begin
      @(negedge clk);
      if (reset || !(bus.mem_read || bus.mem_write)) begin
        resp_active   = 1'b0;
        resp_cnt      = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'($urandom);
      end else begin
        if (!resp_active) begin
          resp_active = 1'b1;
          resp_bogus  = (acc_q.size() == 0);
          if (resp_bogus) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_access: got addr %0h expected no access", bus.mem_addr);
          end else begin
            cur_acc = acc_q.pop_front();
          end
        end
        resp_cnt++;
        if (!resp_bogus) begin
          check("mem_addr", bus.mem_addr, cur_acc.addr);
          check("mem_write", bus.mem_write, cur_acc.wr);
          check("mem_read", bus.mem_read, !cur_acc.wr);
          if (cur_acc.wr) check("mem_wdata", bus.mem_wdata, cur_acc.wdata);
        end
        if (!resp_bogus && resp_cnt == cur_acc.lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = phys_mem.exists(cur_acc.addr) ? phys_mem[cur_acc.addr]
                                                        : default_word(cur_acc.addr);
          if (cur_acc.wr) phys_mem[cur_acc.addr] = bus.mem_wdata;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = 16'($urandom);
        end
      end
    end
  end

  // Monitor: stall rule every cycle, scoreboard pop on each ready pulse.
  initial begin
    resp_t r;
    forever begin
      @(posedge clk);
      #1;
      check("stall_if", bus.stall_if, bus.if_ready ? 1'b0 : bus.if_req);
      check("stall_mem", bus.stall_mem, bus.dm_ready ? 1'b0 : (bus.dm_read | bus.dm_write));
      for (int p = 0; p < 2; p++) begin
        if ((p == 0 && bus.if_ready) || (p == 1 && bus.dm_ready)) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_ready: got ready on %s expected none", p == 0 ? "IF" : "DM");
          end else begin
            r = exp_q.pop_front();
            check("ready_port", (p == 0), r.is_if);
            check("rdata", (p == 0) ? bus.if_rdata : bus.dm_rdata, r.rdata);
            check("timeout_err", bus.timeout_err, r.err);
            $display("txn port=%s rdata=%h timeout_err=%0d", p == 0 ? "IF" : "DM",
                     (p == 0) ? bus.if_rdata : bus.dm_rdata, bus.timeout_err);
          end
        end
      end
    end
  end

  initial begin
    int          k;
    int          dm_kind;
    logic [15:0] ra;
    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 16'h0;
    bus.dm_read = 1'b0; bus.dm_write = 1'b0; bus.dm_addr = 16'h0; bus.dm_wdata = 16'h0;
    model_err = 1'b0; model_last_if = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_if_ready", bus.if_ready, 1'b0);
    check("rst_dm_ready", bus.dm_ready, 1'b0);
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 16'h0);
    check("rst_mem_wdata", bus.mem_wdata, 16'h0);
    check("rst_if_rdata", bus.if_rdata, 16'h0);
    check("rst_dm_rdata", bus.dm_rdata, 16'h0);
    check("rst_timeout_err", bus.timeout_err, 1'b0);
    reset = 1'b0;
    model_mem[16'h0010] = 16'h6001;
    phys_mem[16'h0010]  = 16'h6001;

    start_round(1, 0, 0, 16'h0010, 16'h0, 16'h0, 2, 0);            finish_round(1, 0);
    start_round(1, 1, 0, 16'h0040, 16'h0040, 16'h0, 2, 2);         finish_round(1, 1);
    start_round(0, 0, 1, 16'h0, 16'h0080, 16'hBEEF, 0, 3);         finish_round(0, 1);
    start_round(0, 1, 0, 16'h0, 16'h0080, 16'h0, 0, 1);            finish_round(0, 1);
    start_round(0, 1, 1, 16'h0, 16'h0081, 16'h1234, 0, 1);         finish_round(0, 1);
    start_round(0, 1, 0, 16'h0, 16'h0081, 16'h0, 0, 2);            finish_round(0, 1);
    start_round(1, 0, 0, 16'h0011, 16'h0, 16'h0, 15, 0);           finish_round(1, 0);

    for (int n = 0; n < 40; n++) begin
      k       = int'($urandom_range(0, 4));
      dm_kind = (k == 4) ? int'($urandom_range(1, 3)) : ((k == 0) ? 0 : k);
      ra      = 16'($urandom_range(0, 15));
      start_round(k == 0 || k == 4, dm_kind[0], dm_kind[1], ra,
                  16'($urandom_range(0, 15)), 16'($urandom), rand_lat(), rand_lat());
      finish_round(k == 0 || k == 4, dm_kind != 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    start_round(1, 0, 0, 16'h0099, 16'h0, 16'h0, 16, 0);           finish_round(1, 0);
    repeat (3) begin
      @(negedge clk);
      check("timeout_sticky", bus.timeout_err, 1'b1);
    end

    // Reset in the middle of a data grant that memory never acks.
    @(negedge clk);
    begin
      acc_t a;
      a.addr = 16'h0055; a.wr = 1'b0; a.wdata = 16'h0; a.lat = 100;
      acc_q.push_back(a);
    end
    bus.dm_read = 1'b1; bus.dm_addr = 16'h0055;
    repeat (3) @(negedge clk);
    check("abort_pre_read", bus.mem_read, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("abort_mem_read", bus.mem_read, 1'b0);
    check("abort_mem_write", bus.mem_write, 1'b0);
    check("abort_mem_addr", bus.mem_addr, 16'h0);
    check("abort_timeout_err", bus.timeout_err, 1'b0);
    bus.dm_read = 1'b0;
    model_err = 1'b0; model_last_if = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_dm_ready", bus.dm_ready, 1'b0);
    end

    // Request already present at release must be granted on the first edge.
    start_round(1, 0, 0, 16'h0033, 16'h0, 16'h0, 1, 0);
    reset = 1'b0;
    @(negedge clk);
    check("first_edge_grant", bus.mem_read, 1'b1);
    finish_round(1, 0);

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("acc_q_drained", acc_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
